// File: rtl/fifo_rd_stream.sv
// Read-side drain adapter for async_fifo: turns rden/empty/registered-rdata into a
// valid/ready stream through a 2-entry buffer, popping only when a slot is guaranteed.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   output logic                  o_fifo_rden,
   input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
   input  logic                  i_fifo_empty,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   input  logic                  i_ready,
   output logic [1:0]            o_level,
   output logic [CNT_WIDTH-1:0]  o_count
);

   logic [1:0]            occ_q, occ_d;
   logic                  infl_q, infl_d;
   logic                  head_q, head_d;
   logic                  tail_q, tail_d;
   logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
   logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  pop_s;
   logic [2:0]            credit_s;

   assign o_valid = (occ_q != 2'd0);
   assign pop_s   = o_valid & i_ready;

   // Occupancy after this edge, counting the word already in flight; never
   // underflows because a pop needs at least one buffered word.
   assign credit_s    = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop_s};
   assign o_fifo_rden = i_rst_n & ~i_fifo_empty & (credit_s < 3'd2);

   assign o_data  = head_q ? slot1_q : slot0_q;
   assign o_level = occ_q;
   assign o_count = count_q;

   // Next-state: land the in-flight word at tail, retire the head on a pop.
   always_comb begin
      occ_d   = credit_s[1:0];
      infl_d  = o_fifo_rden;
      head_d  = head_q;
      tail_d  = tail_q;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      if (infl_q) begin
         if (tail_q) begin
            slot1_d = i_fifo_rdata;
         end else begin
            slot0_d = i_fifo_rdata;
         end
         tail_d = ~tail_q;
      end else begin
         tail_d = tail_q;
      end
      if (pop_s) begin
         head_d  = ~head_q;
         count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         head_d  = head_q;
         count_d = count_q;
      end
   end

   // State registers; reset discards buffered and in-flight words alike.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         occ_q   <= 2'd0;
         infl_q  <= 1'b0;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         slot0_q <= {DATA_WIDTH{1'b0}};
         slot1_q <= {DATA_WIDTH{1'b0}};
         count_q <= {CNT_WIDTH{1'b0}};
      end else begin
         occ_q   <= occ_d;
         infl_q  <= infl_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT and
// a scoreboard of popped-but-undelivered words predicts every stream output.
module tb_fifo_rd_stream;
   localparam int DW = 8;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rden;
   logic [DW-1:0] rdata = '0;
   logic          empty = 1'b1;
   logic          valid;
   logic [DW-1:0] data;
   logic          ready = 1'b0;
   logic [1:0]    level;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .o_fifo_rden(rden), .i_fifo_rdata(rdata),
      .i_fifo_empty(empty), .o_valid(valid), .o_data(data), .i_ready(ready),
      .o_level(level), .o_count(count)
   );

   int n_vec = 0;
   int n_err = 0;
   int pop_empty = 0;

   // FIFO contents and words taken from the FIFO but not yet accepted downstream.
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] sb_q[$];
   bit            infl_m = 1'b0;
   logic [CW-1:0] cnt_m = '0;
   bit            gap = 1'b0;

   bit            exp_rden, exp_valid, pop_m;
   logic [DW-1:0] exp_data;
   logic [1:0]    exp_level;
   logic [CW-1:0] exp_count;
   int            landed;

   task automatic model_clear();
      sb_q.delete();
      infl_m = 1'b0;
      cnt_m  = '0;
   endtask

   // Drive inputs for this cycle and derive what the stream must show.
   task automatic prep(input bit rdy);
      ready = rdy;
      empty = gap || (fifo_q.size() == 0);
      #1;
      landed    = sb_q.size() - int'(infl_m);
      exp_valid = (landed > 0);
      exp_level = 2'(landed);
      exp_data  = exp_valid ? sb_q[0] : '0;
      exp_count = cnt_m;
      pop_m     = exp_valid & rdy;
      exp_rden  = rst_n & ~empty & ((landed + int'(infl_m) - int'(pop_m)) < 2);
   endtask

   // Clock edge: the FIFO model answers the DUT's actual pop one cycle later.
   task automatic tick();
      bit            pushed;
      logic [DW-1:0] w;
      pushed = 1'b0;
      w = rdata;
      if (rden) begin
         if (empty || fifo_q.size() == 0) begin
            pop_empty++;
         end else begin
            w = fifo_q.pop_front();
            sb_q.push_back(w);
            pushed = 1'b1;
         end
      end
      if (pop_m) void'(sb_q.pop_front());
      cnt_m  = cnt_m + CW'(pop_m);
      infl_m = pushed;
      @(posedge clk);
      #1;
      if (pushed) rdata = w;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; empty = 1'b0; ready = 1'b1;
      #3;
      n_vec++; if (rden !== 1'b0) begin n_err++; $display("FAIL reset_rden got %b exp 0", rden); end
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", valid); end
      n_vec++; if (level !== 2'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", level); end
      n_vec++; if (count !== 16'h0000) begin n_err++; $display("FAIL reset_count got %0h exp 0", count); end
      n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data got %0h exp 0", data); end
      @(posedge clk); @(posedge clk); #1;
      n_vec++; if ({rden, valid, level} !== 4'b0000) begin n_err++; $display("FAIL reset_hold got %b exp 0000", {rden, valid, level}); end
      empty = 1'b1; gap = 1'b0; model_clear(); fifo_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int rd_n = 0, v_n = 0, rd_at = -1, v_at = -1;
      fifo_q.push_back(8'hA5);
      for (int i = 0; i < 8; i++) begin
         prep(1'b1);
         n_vec++; if (rden !== exp_rden) begin n_err++; $display("FAIL single_rden cyc %0d got %b exp %b", i, rden, exp_rden); end
         n_vec++; if ({valid, level, count} !== {exp_valid, exp_level, exp_count}) begin n_err++; $display("FAIL single_status cyc %0d got %b/%0d/%0h exp %b/%0d/%0h", i, valid, level, count, exp_valid, exp_level, exp_count); end
         if (exp_valid) begin n_vec++; if (data !== 8'hA5) begin n_err++; $display("FAIL single_data got %0h exp a5", data); end end
         if (rden)  begin rd_n++; rd_at = i; end
         if (valid) begin v_n++;  v_at = i; end
         tick();
      end
      n_vec++; if (rd_n != 1) begin n_err++; $display("FAIL single_rden_pulses got %0d exp 1", rd_n); end
      n_vec++; if (v_n != 1) begin n_err++; $display("FAIL single_valid_cycles got %0d exp 1", v_n); end
      n_vec++; if (v_at - rd_at != 2) begin n_err++; $display("FAIL single_latency got %0d exp 2", v_at - rd_at); end
      n_vec++; if (count !== 16'd1) begin n_err++; $display("FAIL single_count got %0d exp 1", count); end
   endtask

   task automatic test_streaming();
      int rd_n = 0, rd_first = -1, rd_last = -1, v_n = 0, v_first = -1, v_last = -1;
      logic [CW-1:0] base;
      base = cnt_m;
      for (int k = 0; k < 138; k++) fifo_q.push_back(DW'($urandom()));
      for (int i = 0; i < 160; i++) begin
         prep(1'b1);
         n_vec++; if (rden !== exp_rden) begin n_err++; $display("FAIL stream_rden cyc %0d got %b exp %b", i, rden, exp_rden); end
         n_vec++; if ({valid, level, count} !== {exp_valid, exp_level, exp_count}) begin n_err++; $display("FAIL stream_status cyc %0d got %b/%0d/%0h exp %b/%0d/%0h", i, valid, level, count, exp_valid, exp_level, exp_count); end
         if (exp_valid) begin n_vec++; if (data !== exp_data) begin n_err++; $display("FAIL stream_data cyc %0d got %0h exp %0h", i, data, exp_data); end end
         if (rden)  begin rd_n++; if (rd_first < 0) rd_first = i; rd_last = i; end
         if (valid) begin v_n++;  if (v_first < 0) v_first = i; v_last = i; end
         tick();
      end
      n_vec++; if (rd_n != 138 || rd_last - rd_first != 137) begin n_err++; $display("FAIL stream_rden_run got %0d over %0d cycles exp 138", rd_n, rd_last - rd_first + 1); end
      n_vec++; if (v_n != 138 || v_last - v_first != 137) begin n_err++; $display("FAIL stream_valid_run got %0d over %0d cycles exp 138", v_n, v_last - v_first + 1); end
      n_vec++; if (count !== base + 16'd138) begin n_err++; $display("FAIL stream_count got %0d exp %0d", count, base + 16'd138); end
   endtask

   task automatic test_backpressure();
      int peak = 0;
      bit stalled = 1'b0;
      logic [DW-1:0] held = '0;
      for (int k = 0; k < 60; k++) fifo_q.push_back(DW'($urandom()));
      for (int i = 0; i < 100; i++) begin
         prep(!(i >= 10 && i < 15));
         n_vec++; if (rden !== exp_rden) begin n_err++; $display("FAIL bp_rden cyc %0d got %b exp %b", i, rden, exp_rden); end
         n_vec++; if ({valid, level, count} !== {exp_valid, exp_level, exp_count}) begin n_err++; $display("FAIL bp_status cyc %0d got %b/%0d/%0h exp %b/%0d/%0h", i, valid, level, count, exp_valid, exp_level, exp_count); end
         if (exp_valid) begin n_vec++; if (data !== exp_data) begin n_err++; $display("FAIL bp_data cyc %0d got %0h exp %0h", i, data, exp_data); end end
         if (stalled) begin n_vec++; if (valid !== 1'b1 || data !== held) begin n_err++; $display("FAIL bp_stable cyc %0d got %b/%0h exp 1/%0h", i, valid, data, held); end end
         if (int'(level) > peak) peak = int'(level);
         stalled = valid & ~ready;
         held = data;
         tick();
      end
      n_vec++; if (peak != 2) begin n_err++; $display("FAIL bp_peak got %0d exp 2", peak); end
      n_vec++; if (sb_q.size() != 0 || fifo_q.size() != 0) begin n_err++; $display("FAIL bp_drain got %0d left exp 0", sb_q.size() + fifo_q.size()); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if (i < 400) begin
            if ($urandom_range(0, 99) < 45 && fifo_q.size() < 128) fifo_q.push_back(DW'($urandom()));
            gap = ($urandom_range(0, 3) == 0);
         end else begin
            gap = 1'b0;
         end
         prep((i < 400) ? 1'($urandom_range(0, 1)) : 1'b1);
         n_vec++; if (rden !== exp_rden) begin n_err++; $display("FAIL rand_rden cyc %0d got %b exp %b", i, rden, exp_rden); end
         n_vec++; if ({valid, level, count} !== {exp_valid, exp_level, exp_count}) begin n_err++; $display("FAIL rand_status cyc %0d got %b/%0d/%0h exp %b/%0d/%0h", i, valid, level, count, exp_valid, exp_level, exp_count); end
         if (exp_valid) begin n_vec++; if (data !== exp_data) begin n_err++; $display("FAIL rand_data cyc %0d got %0h exp %0h", i, data, exp_data); end end
         tick();
      end
      n_vec++; if (pop_empty != 0) begin n_err++; $display("FAIL rand_pop_while_empty got %0d exp 0", pop_empty); end
      n_vec++; if (sb_q.size() != 0 || fifo_q.size() != 0) begin n_err++; $display("FAIL rand_drain got %0d left exp 0", sb_q.size() + fifo_q.size()); end
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < 2; k++) begin
         bit seen = 1'b0;
         for (int w = 0; w < 20; w++) fifo_q.push_back(DW'($urandom()));
         for (int i = 0; i < 6 + k; i++) begin
            prep(!(k == 1 && i == 6));
            tick();
         end
         n_vec++; if (level !== ((k == 1) ? 2'd2 : 2'd1)) begin n_err++; $display("FAIL mrst_preload k%0d got %0d exp %0d", k, level, (k == 1) ? 2 : 1); end
         #2; rst_n = 1'b0; #1;
         n_vec++; if ({rden, valid, level} !== 4'b0000) begin n_err++; $display("FAIL mrst_async k%0d got %b exp 0000", k, {rden, valid, level}); end
         n_vec++; if ({count, data} !== 24'h000000) begin n_err++; $display("FAIL mrst_regs k%0d got %0h/%0h exp 0/0", k, count, data); end
         model_clear(); fifo_q.delete(); gap = 1'b0;
         @(posedge clk); #1;
         rst_n = 1'b1;
         fifo_q.push_back(8'h3C);
         for (int i = 0; i < 6; i++) begin
            prep(1'b1);
            n_vec++; if (rden !== exp_rden) begin n_err++; $display("FAIL mrst_rden cyc %0d got %b exp %b", i, rden, exp_rden); end
            n_vec++; if ({valid, level, count} !== {exp_valid, exp_level, exp_count}) begin n_err++; $display("FAIL mrst_status cyc %0d got %b/%0d/%0h exp %b/%0d/%0h", i, valid, level, count, exp_valid, exp_level, exp_count); end
            if (valid && data === 8'h3C) seen = 1'b1;
            tick();
         end
         n_vec++; if (!seen || count !== 16'd1) begin n_err++; $display("FAIL mrst_recover k%0d got seen=%b count=%0d exp 1/1", k, seen, count); end
      end
   endtask

   task automatic test_count_wrap();
      bit wrapped = 1'b0;
      logic [CW-1:0] prev;
      for (int k = 0; k < 65536; k++) fifo_q.push_back(DW'(k ^ (k >> 8)));
      prev = count;
      for (int i = 0; i < 65545; i++) begin
         prep(1'b1);
         n_vec++; if (rden !== exp_rden) begin n_err++; $display("FAIL wrap_rden cyc %0d got %b exp %b", i, rden, exp_rden); end
         n_vec++; if ({valid, level, count} !== {exp_valid, exp_level, exp_count}) begin n_err++; $display("FAIL wrap_status cyc %0d got %b/%0d/%0h exp %b/%0d/%0h", i, valid, level, count, exp_valid, exp_level, exp_count); end
         if (exp_valid) begin n_vec++; if (data !== exp_data) begin n_err++; $display("FAIL wrap_data cyc %0d got %0h exp %0h", i, data, exp_data); end end
         if (prev === 16'hFFFF && count === 16'h0000) wrapped = 1'b1;
         prev = count;
         tick();
      end
      n_vec++; if (!wrapped) begin n_err++; $display("FAIL wrap_seen got 0 exp 1"); end
      n_vec++; if (count !== 16'd1) begin n_err++; $display("FAIL wrap_final got %0h exp 1", count); end
      n_vec++; if (sb_q.size() != 0 || fifo_q.size() != 0) begin n_err++; $display("FAIL wrap_drain got %0d left exp 0", sb_q.size() + fifo_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_streaming();
      test_backpressure();
      test_random();
      test_mid_reset();
      test_count_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
